mac_accum_stage: RTL and testbench
==================================

// Module: mac_accum_stage
// PURPOSE
//  Downstream consumer of the 16x16 multiplier stage (accurate / approx modes).
//  Accepts a stream of 32-bit unsigned products via valid/ready.
//  Accumulates VEC_LEN products into a saturating ACC_W-bit register and presents
//  the dot-product result with a valid/ready handshake.
//  Together with the multipliers it forms the MAC unit used for error/energy comparison.
// PARAMETERS
//  PROD_W  32  product width from multiplier stage (unsigned)
//  ACC_W   40  accumulator width; must be >= PROD_W
//  LEN_W   8   width of vector-length field (max 2^LEN_W-1 products per job)
// PORTS
//  clk        in   1       single clock, all logic rising-edge
//  rst        in   1       synchronous, active-high reset
//  start      in   1       job start pulse; sampled only in IDLE
//  vec_len    in   LEN_W   products in job; sampled with start
//  prod_valid in   1       product available from multiplier stage
//  prod       in   PROD_W  product value, unsigned
//  prod_ready out  1       stage accepts a product this cycle
//  res_valid  out  1       result available
//  res_ready  in   1       downstream accepts result
//  res_data   out  ACC_W   accumulated sum
//  res_sat    out  1       sticky: accumulator saturated during job
//  busy       out  1       high in ACCUM or DONE
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=IDLE; acc=0; cnt=0; sat=0.
//   All outputs 0: prod_ready, res_valid, res_data, res_sat, busy.
//   Reset mid-job discards the job; no result is produced.
//  FSM states: IDLE, ACCUM, DONE.
//  IDLE:
//   - prod_ready=0, res_valid=0.
//   - On start=1, latch vec_len; clear acc, cnt and sat.
//   - vec_len!=0 -> ACCUM. vec_len==0 -> DONE with res_data=0, res_sat=0.
//  ACCUM:
//   - prod_ready=1. A product transfers when prod_valid & prod_ready.
//   - On transfer: acc <= min(acc + zext(prod), 2^ACC_W-1). Saturation is detected
//     from the carry out of the ACC_W+1-bit sum. sat is sticky once set.
//   - On transfer: cnt++. On the transfer with cnt==len-1 -> DONE.
//   - Cycles without prod_valid are stalls: no state change.
//  DONE:
//   - res_valid=1; res_data=acc; res_sat=sat; prod_ready=0.
//   - res_data and res_sat stay stable while res_valid & !res_ready.
//   - On res_ready=1 -> IDLE. The next start is accepted one cycle later at the earliest.
//  Latency: res_valid rises the cycle after the last product transfer.
//  Throughput: 1 product/cycle in ACCUM. Job overhead is 1 cycle for start and
//   at least 1 cycle for the result handshake.
//  start in ACCUM or DONE is ignored; in-flight vec_len is unaffected.
//  busy=1 in ACCUM and DONE; 0 in IDLE.
//  res_data, res_sat are held at the last result value in IDLE. They are cleared only by rst.
// TESTING
//  1 start, vec_len=4, prods 10,20,30,40 back-to-back
//    -> res_valid rises 1 cycle after the 4th transfer; res_data=100, res_sat=0.
//  2 vec_len=3, prod_valid toggled 1,0,0,1,0,1 with prods 5,7,9
//    -> exactly 3 transfers; res_data=21; prod_ready=1 throughout ACCUM.
//  3 ACC_W=33, vec_len=3, prods 0xFFFF_FFFF x3
//    -> res_data=0x1_FFFF_FFFF (saturated), res_sat=1.
//  4 start with vec_len=0
//    -> res_valid=1 next cycle, res_data=0; no product is accepted.
//  5 hold res_ready=0 for 5 cycles in DONE; pulse start meanwhile
//    -> res_data stable, start ignored; IDLE after res_ready=1.
//  6 rst asserted after 2 of 4 products
//    -> all outputs 0 next cycle, state IDLE; a fresh job of 2x 3 yields res_data=6.

Source files
------------

// File: rtl/mac_accum_stage.sv
// Saturating dot-product accumulator fed by the multiplier stage.
// It collects vec_len unsigned products and returns the sum through a valid/ready handshake.
module mac_accum_stage #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_sat,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Bit ACC_W of the result flags an overflow; the value is then clamped to all ones.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [PROD_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
    if (s[ACC_W]) begin
      sat_add = {1'b1, {ACC_W{1'b1}}};
    end else begin
      sat_add = s;
    end
  endfunction

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               sat_q, sat_d;
  logic [ACC_W-1:0]   res_data_q, res_data_d;
  logic               res_sat_q, res_sat_d;
  logic               res_valid_q, res_valid_d;
  logic               prod_ready_q, prod_ready_d;
  logic               busy_q, busy_d;
  logic [ACC_W:0]     sum_s;
  logic               xfer_s;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    res_data_d = res_data_q;
    res_sat_d  = res_sat_q;
    sum_s      = sat_add(acc_q, prod);
    xfer_s     = prod_valid & prod_ready_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d = vec_len;
          acc_d = {ACC_W{1'b0}};
          cnt_d = {LEN_W{1'b0}};
          sat_d = 1'b0;
          if (vec_len != {LEN_W{1'b0}}) begin
            state_d = S_ACCUM;
          end else begin
            state_d    = S_DONE;
            res_data_d = {ACC_W{1'b0}};
            res_sat_d  = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (xfer_s) begin
          acc_d = sum_s[ACC_W-1:0];
          sat_d = sat_q | sum_s[ACC_W];
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d    = S_DONE;
            res_data_d = sum_s[ACC_W-1:0];
            res_sat_d  = sat_q | sum_s[ACC_W];
          end else begin
            state_d = S_ACCUM;
          end
        end else begin
          state_d = S_ACCUM;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake outputs are decoded from the next state so they register alongside it.
    prod_ready_d = (state_d == S_ACCUM);
    res_valid_d  = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= {LEN_W{1'b0}};
      cnt_q        <= {LEN_W{1'b0}};
      acc_q        <= {ACC_W{1'b0}};
      sat_q        <= 1'b0;
      res_data_q   <= {ACC_W{1'b0}};
      res_sat_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      prod_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      sat_q        <= sat_d;
      res_data_q   <= res_data_d;
      res_sat_q    <= res_sat_d;
      res_valid_q  <= res_valid_d;
      prod_ready_q <= prod_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign prod_ready = prod_ready_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_sat    = res_sat_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mac_accum_stage.sv
// Bench for mac_accum_stage: two instances (ACC_W=40 and ACC_W=33) share one stimulus stream
// and are checked against a plain-arithmetic dot-product reference.
module tb_mac_accum_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  vec_len;
  logic        prod_valid;
  logic [31:0] prod;
  logic        res_ready;

  logic        prod_ready_a, res_valid_a, res_sat_a, busy_a;
  logic [39:0] res_data_a;
  logic        prod_ready_b, res_valid_b, res_sat_b, busy_b;
  logic [32:0] res_data_b;

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] MAX40 = 64'h0000_00FF_FFFF_FFFF;
  localparam logic [63:0] MAX33 = 64'h0000_0001_FFFF_FFFF;

  logic [31:0] prods_q[$];
  bit          valid_pat[$];

  always #5 clk = ~clk;

  mac_accum_stage #(.PROD_W(32), .ACC_W(40), .LEN_W(8)) u_dut40 (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready_a),
    .res_valid(res_valid_a), .res_ready(res_ready), .res_data(res_data_a),
    .res_sat(res_sat_a), .busy(busy_a)
  );

  mac_accum_stage #(.PROD_W(32), .ACC_W(33), .LEN_W(8)) u_dut33 (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready_b),
    .res_valid(res_valid_b), .res_ready(res_ready), .res_data(res_data_b),
    .res_sat(res_sat_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctrl(input string tag, input bit ready, input bit valid, input bit bsy);
    chk({tag, ".prod_ready40"}, 64'(prod_ready_a), 64'(ready));
    chk({tag, ".prod_ready33"}, 64'(prod_ready_b), 64'(ready));
    chk({tag, ".res_valid40"},  64'(res_valid_a),  64'(valid));
    chk({tag, ".res_valid33"},  64'(res_valid_b),  64'(valid));
    chk({tag, ".busy40"},       64'(busy_a),       64'(bsy));
    chk({tag, ".busy33"},       64'(busy_b),       64'(bsy));
  endtask

  task automatic chk_result(input string tag, input logic [63:0] e40, input bit s40,
                            input logic [63:0] e33, input bit s33);
    chk({tag, ".data40"}, 64'(res_data_a), e40);
    chk({tag, ".sat40"},  64'(res_sat_a),  64'(s40));
    chk({tag, ".data33"}, 64'(res_data_b), e33);
    chk({tag, ".sat33"},  64'(res_sat_b),  64'(s33));
  endtask

  // One job: products come from prods_q, valid pattern from valid_pat (then random or always-1).
  task automatic run_job(input string tag, input int len, input int hold,
                         input bit rand_stall, input bit poke_start);
    logic [63:0] total;
    logic [63:0] e40, e33;
    bit          s40, s33;
    int          sent;
    int          guard;
    bit          v;

    total = 64'd0;
    for (int i = 0; i < len; i++) total += 64'(prods_q[i]);
    s40 = (total > MAX40);
    s33 = (total > MAX33);
    e40 = s40 ? MAX40 : total;
    e33 = s33 ? MAX33 : total;

    start   = 1'b1;
    vec_len = 8'(len);
    step();
    start = 1'b0;
    chk_ctrl({tag, ".after_start"}, len != 0, len == 0, 1'b1);

    sent  = 0;
    guard = 0;
    while (sent < len && guard < 2000) begin
      if (valid_pat.size() != 0) v = valid_pat.pop_front();
      else if (rand_stall) v = ($urandom_range(0, 1) == 1);
      else v = 1'b1;
      prod_valid = v;
      prod       = v ? prods_q[sent] : $urandom;
      if (poke_start) begin
        start   = ($urandom_range(0, 2) == 0);
        vec_len = 8'($urandom_range(0, 255));
      end
      step();
      if (v) sent++;
      guard++;
      chk_ctrl({tag, ".accum"}, sent < len, sent == len, 1'b1);
    end
    if (guard >= 2000) chk({tag, ".accum_timeout"}, 64'(sent), 64'(len));
    prod_valid = 1'b0;
    start      = 1'b0;
    chk_result({tag, ".done"}, e40, s40, e33, s33);

    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      prod_valid = 1'b1;
      prod       = $urandom;
      start      = (h % 2 == 0);
      vec_len    = 8'($urandom_range(1, 255));
      step();
      chk_ctrl({tag, ".hold"}, 1'b0, 1'b1, 1'b1);
      chk_result({tag, ".hold"}, e40, s40, e33, s33);
    end
    prod_valid = 1'b0;
    start      = 1'b0;
    res_ready  = 1'b1;
    step();
    res_ready = 1'b0;
    chk_ctrl({tag, ".idle"}, 1'b0, 1'b0, 1'b0);
    chk_result({tag, ".idle_held"}, e40, s40, e33, s33);
    prods_q.delete();
    valid_pat.delete();
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    start      = 1'b0;
    vec_len    = 8'd0;
    prod_valid = 1'b0;
    prod       = 32'd0;
    res_ready  = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk_ctrl("reset", 1'b0, 1'b0, 1'b0);
    chk_result("reset", 64'd0, 1'b0, 64'd0, 1'b0);

    // Back-to-back products.
    prods_q = '{32'd10, 32'd20, 32'd30, 32'd40};
    run_job("t1", 4, 0, 1'b0, 1'b0);

    // Stalled valid pattern.
    prods_q   = '{32'd5, 32'd7, 32'd9};
    valid_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_job("t2", 3, 1, 1'b0, 1'b0);

    // Saturation at 33 bits; fits in 40 bits.
    prods_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    run_job("t3", 3, 0, 1'b0, 1'b0);

    // Empty job, products offered during DONE must be refused.
    run_job("t4", 0, 2, 1'b0, 1'b0);

    // Long result back-pressure with start pulses.
    prods_q = '{32'd1000, 32'd2000};
    run_job("t5", 2, 5, 1'b0, 1'b0);

    // Reset in the middle of a job.
    start   = 1'b1;
    vec_len = 8'd4;
    step();
    start      = 1'b0;
    prod_valid = 1'b1;
    prod       = 32'd111;
    step();
    step();
    prod_valid = 1'b0;
    rst        = 1'b1;
    step();
    rst = 1'b0;
    chk_ctrl("t6.reset", 1'b0, 1'b0, 1'b0);
    chk_result("t6.reset", 64'd0, 1'b0, 64'd0, 1'b0);
    prods_q = '{32'd3, 32'd3};
    run_job("t6.fresh", 2, 0, 1'b0, 1'b0);

    // Randomized jobs with stalls, ignored start pulses and occasional big products.
    for (int j = 0; j < 30; j++) begin
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) prods_q.push_back(32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
        else prods_q.push_back($urandom);
      end
      run_job("rand", n, $urandom_range(0, 3), 1'b1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
